// File: rtl/mat_stream_loader.sv
// Element-serial loader for the matrix inversion kernel.
// Packs row-major beats into a flat matrix bus and meters launches by credit.
module mat_stream_loader #(
    parameter int MAT_SIZE        = 5,
    parameter int MAT_DWIDTH      = 46,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [MAT_DWIDTH-1:0]                     s_data,
    input  logic                                      s_valid,
    input  logic                                      s_last,
    output logic                                      s_ready,
    output logic [MAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0]   mat_in,
    output logic                                      mat_vld,
    input  logic                                      inv_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
    output logic                                      frame_err,
    output logic                                      credit_err
);

    localparam int NN = MAT_SIZE * MAT_SIZE;
    localparam int MW = MAT_DWIDTH * NN;
    localparam int KW = (NN > 1) ? $clog2(NN) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
    localparam logic [OW-1:0] O_MAX  = OW'(MAX_OUTSTANDING);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k;
    logic [MW-1:0]   r_asm;
    logic [MW-1:0]   r_launch;
    logic            r_launch_full;
    logic            r_mat_vld;
    logic [OW-1:0]   r_out;
    logic            r_frame_err;
    logic            r_credit_err;

    logic            w_acc;
    logic            w_k_last;
    logic            w_copy;
    logic            w_fire;

    assign s_ready     = (r_state == S_FILL) && !reset;
    assign w_acc       = s_valid && s_ready;
    assign w_k_last    = (r_k == K_LAST);
    assign w_fire      = r_launch_full && (r_out < O_MAX);
    assign mat_in      = r_launch;
    assign mat_vld     = r_mat_vld;
    assign outstanding = r_out;
    assign frame_err   = r_frame_err;
    assign credit_err  = r_credit_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_nxt;
    end

    // Next state; copy into the launch register only when it is empty.
    always_comb begin
        w_state_nxt = r_state;
        w_copy      = 1'b0;
        unique case (r_state)
            S_FILL: begin
                if (w_acc && w_k_last) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!r_launch_full) begin
                    w_copy      = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Element counter and assembly buffer; early s_last drops the partial.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k   <= '0;
            r_asm <= '0;
        end else if (w_acc) begin
            r_asm[MAT_DWIDTH*int'(r_k) +: MAT_DWIDTH] <= s_data;
            if (w_k_last || s_last) r_k <= '0;
            else                    r_k <= r_k + 1'b1;
        end
    end

    // Sticky framing error when s_last disagrees with the element position.
    always_ff @(posedge clk) begin
        if (reset)                             r_frame_err <= 1'b0;
        else if (w_acc && (s_last != w_k_last)) r_frame_err <= 1'b1;
    end

    // Launch register, its full flag and the one-cycle launch pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_launch      <= '0;
            r_launch_full <= 1'b0;
            r_mat_vld     <= 1'b0;
        end else begin
            r_mat_vld <= w_fire;
            if (w_copy) begin
                r_launch      <= r_asm;
                r_launch_full <= 1'b1;
            end else if (w_fire) begin
                r_launch_full <= 1'b0;
            end
        end
    end

    // Credit counter; a return with nothing in flight is flagged, not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out        <= '0;
            r_credit_err <= 1'b0;
        end else begin
            unique case ({r_mat_vld, inv_done})
                2'b10: r_out <= r_out + 1'b1;
                2'b01: begin
                    if (r_out == '0) r_credit_err <= 1'b1;
                    else             r_out <= r_out - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
